ub_read_sequencer: RTL and testbench

Read-address sequencer that sits directly upstream of the unified buffer's two read ports. On a start command it streams a run of row addresses to the input port and the weight port in lockstep. It tags the first and last beat of each stream with first/last markers. It then waits a programmable drain interval so the systolic array can flush, and signals completion with a done pulse.

---
 rtl/ub_read_sequencer.sv | 147 ++++++++++++++
 tb/tb_ub_read_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ub_read_sequencer.sv
// Read-address sequencer feeding the unified buffer's input and weight read ports.
// Streams strided row addresses in lockstep with first/last markers, drains, then pulses done.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

// state  | meaning
// IDLE   | waiting for start; addresses hold, markers/busy/done low
// STREAM | one beat per cycle on both ports
// DRAIN  | idle gap so the systolic array can flush
// DONE   | single-cycle done pulse
module ub_read_sequencer #(
    parameter int ADDR_W       = `ADDR_WIDTH,
    parameter int LEN_W        = 16,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_input_base,
    input  logic [ADDR_W-1:0] cfg_input_stride,
    input  logic [ADDR_W-1:0] cfg_weight_base,
    input  logic [ADDR_W-1:0] cfg_weight_stride,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic [ADDR_W-1:0] input_addr,
    output logic              input_first,
    output logic              input_last,
    output logic [ADDR_W-1:0] weight_addr,
    output logic              weight_first,
    output logic              weight_last,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] istride;
    logic [ADDR_W-1:0] wstride;
    logic [LEN_W-1:0]  beats_left;
    logic [CNT_W-1:0]  drain_cnt;
    logic              first_q;
    logic              last_q;

    // Both ports always see identical markers; one register pair drives both.
    assign input_first  = first_q;
    assign weight_first = first_q;
    assign input_last   = last_q;
    assign weight_last  = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            istride     <= '0;
            wstride     <= '0;
            beats_left  <= '0;
            drain_cnt   <= '0;
            input_addr  <= '0;
            weight_addr <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (abort && state != IDLE) begin
            state      <= IDLE;
            beats_left <= '0;
            drain_cnt  <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    first_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    if (start && !abort) begin
                        istride <= cfg_input_stride;
                        wstride <= cfg_weight_stride;
                        busy    <= 1'b1;
                        if (cfg_len != '0) begin
                            state       <= STREAM;
                            input_addr  <= cfg_input_base;
                            weight_addr <= cfg_weight_base;
                            first_q     <= 1'b1;
                            last_q      <= (cfg_len == LEN_W'(1));
                            beats_left  <= cfg_len - LEN_W'(1);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (beats_left == '0) begin
                        // Last beat is on the outputs now; addresses hold through drain.
                        first_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (DRAIN_CYCLES == 0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end else begin
                        input_addr  <= input_addr + istride;
                        weight_addr <= weight_addr + wstride;
                        first_q     <= 1'b0;
                        last_q      <= (beats_left == LEN_W'(1));
                        beats_left  <= beats_left - LEN_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ub_read_sequencer.sv
// Scoreboard bench for ub_read_sequencer: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them, and flags any done pulse nobody expected.
module tb_ub_read_sequencer;

    localparam int AW = 8;
    localparam int LW = 16;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] cfg_input_base;
    logic [AW-1:0] cfg_input_stride;
    logic [AW-1:0] cfg_weight_base;
    logic [AW-1:0] cfg_weight_stride;
    logic [LW-1:0] cfg_len;
    logic [AW-1:0] input_addr;
    logic          input_first;
    logic          input_last;
    logic [AW-1:0] weight_addr;
    logic          weight_first;
    logic          weight_last;
    logic          busy;
    logic          done;

    ub_read_sequencer #(.ADDR_W(AW), .LEN_W(LW), .DRAIN_CYCLES(D)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .cfg_input_base   (cfg_input_base),
        .cfg_input_stride (cfg_input_stride),
        .cfg_weight_base  (cfg_weight_base),
        .cfg_weight_stride(cfg_weight_stride),
        .cfg_len          (cfg_len),
        .input_addr       (input_addr),
        .input_first      (input_first),
        .input_last       (input_last),
        .weight_addr      (weight_addr),
        .weight_first     (weight_first),
        .weight_last      (weight_last),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            c;
        logic [AW-1:0] ia;
        logic [AW-1:0] wa;
        logic          fi;
        logic          la;
        logic          bz;
        logic          dn;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_chk = 0;
    int            n_bad = 0;
    int            done_seen = 0;
    int            exp_dones = 0;
    int            last_cyc = 0;
    logic [AW-1:0] exp_ia = '0;
    logic [AW-1:0] exp_wa = '0;

    task automatic push(input int c, input logic [AW-1:0] ia, input logic [AW-1:0] wa,
                        input logic fi, input logic la, input logic bz, input logic dn);
        exp_t e;
        e.c = c; e.ia = ia; e.wa = wa; e.fi = fi; e.la = la; e.bz = bz; e.dn = dn;
        exp_q.push_back(e);
    endtask

    // abort_k > 0 means abort is held during cycle t+abort_k (while still streaming).
    task automatic push_run(input int t, input logic [AW-1:0] ib, input logic [AW-1:0] is,
                            input logic [AW-1:0] wb, input logic [AW-1:0] ws,
                            input int len, input int abort_k);
        int nb;
        if (len == 0) begin
            push(t + 1, exp_ia, exp_wa, 1'b0, 1'b0, 1'b1, 1'b1);
            push(t + 2, exp_ia, exp_wa, 1'b0, 1'b0, 1'b0, 1'b0);
            exp_dones++;
            last_cyc = t + 2;
            return;
        end
        nb = (abort_k > 0) ? abort_k : len;
        for (int k = 0; k < nb; k++) begin
            exp_ia = AW'(ib + k * is);
            exp_wa = AW'(wb + k * ws);
            push(t + 1 + k, exp_ia, exp_wa, k == 0, k == len - 1, 1'b1, 1'b0);
        end
        if (abort_k > 0) begin
            push(t + nb + 1, exp_ia, exp_wa, 1'b0, 1'b0, 1'b0, 1'b0);
            last_cyc = t + nb + 1;
        end else begin
            for (int d = 1; d <= D; d++)
                push(t + len + d, exp_ia, exp_wa, 1'b0, 1'b0, 1'b1, 1'b0);
            push(t + len + D + 1, exp_ia, exp_wa, 1'b0, 1'b0, 1'b1, 1'b1);
            push(t + len + D + 2, exp_ia, exp_wa, 1'b0, 1'b0, 1'b0, 1'b0);
            exp_dones++;
            last_cyc = t + len + D + 2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [AW-1:0] ib, input logic [AW-1:0] is,
                             input logic [AW-1:0] wb, input logic [AW-1:0] ws,
                             input int len, input int abort_k);
        push_run(cyc, ib, is, wb, ws, len, abort_k);
        cfg_input_base    = ib;
        cfg_input_stride  = is;
        cfg_weight_base   = wb;
        cfg_weight_stride = ws;
        cfg_len           = LW'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_input_base    = AW'($urandom);
        cfg_input_stride  = AW'($urandom);
        cfg_weight_base   = AW'($urandom);
        cfg_weight_stride = AW'($urandom);
        cfg_len           = LW'($urandom);
    endtask

    task automatic wait_until(input int c);
        int guard = 0;
        while (cyc < c && guard < 200) begin
            tick();
            guard++;
        end
        if (cyc < c) begin
            n_chk++;
            n_bad++;
            $display("FAIL wait_timeout: cycle got %0d expected %0d", cyc, c);
        end
    endtask

    task automatic check_zero(input string name);
        n_chk++;
        if ({input_addr, weight_addr, input_first, weight_first, input_last, weight_last, busy, done} !== '0) begin
            n_bad++;
            $display("FAIL %s: got ia=%h wa=%h f=%b%b l=%b%b busy=%b done=%b expected all zero",
                     name, input_addr, weight_addr, input_first, weight_first,
                     input_last, weight_last, busy, done);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
                mon_e = exp_q.pop_front();
                n_chk++;
                n_bad++;
                $display("FAIL missed_entry: cycle got %0d expected %0d", cyc, mon_e.c);
            end
            if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                mon_e = exp_q.pop_front();
                n_chk++;
                if ({input_addr, weight_addr, input_first, weight_first, input_last, weight_last, busy, done}
                    !== {mon_e.ia, mon_e.wa, mon_e.fi, mon_e.fi, mon_e.la, mon_e.la, mon_e.bz, mon_e.dn}) begin
                    n_bad++;
                    $display("FAIL outputs cyc%0d: got ia=%h wa=%h f=%b%b l=%b%b busy=%b done=%b expected ia=%h wa=%h f=%b l=%b busy=%b done=%b",
                             cyc, input_addr, weight_addr, input_first, weight_first, input_last,
                             weight_last, busy, done, mon_e.ia, mon_e.wa, mon_e.fi, mon_e.la,
                             mon_e.bz, mon_e.dn);
                end
            end else if (done === 1'b1) begin
                n_chk++;
                n_bad++;
                $display("FAIL spurious_done cyc%0d: got done=1 expected done=0", cyc);
            end
            if (done === 1'b1) done_seen++;
        end
    end

    initial begin
        int t0;
        int c0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_input_base = '0; cfg_input_stride = '0;
        cfg_weight_base = '0; cfg_weight_stride = '0;
        cfg_len = '0;
        #12;
        check_zero("reset_state");
        rst_n = 1'b1;
        tick();

        start_run(8'h10, 8'h01, 8'h40, 8'h02, 4, -1);
        wait_until(last_cyc);
        start_run(8'h07, 8'h03, 8'h09, 8'h05, 1, -1);
        wait_until(last_cyc);
        start_run(8'hFE, 8'h01, 8'h80, 8'h40, 4, -1);
        wait_until(last_cyc);
        start_run(8'h33, 8'h01, 8'h55, 8'h01, 0, -1);
        wait_until(last_cyc);

        // Starts during STREAM and during the DONE cycle must both be ignored.
        t0 = cyc;
        start_run(8'h10, 8'h01, 8'h40, 8'h02, 4, -1);
        tick();
        cfg_input_base = 8'hAA; cfg_len = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_until(t0 + 4 + D + 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_until(last_cyc);

        // Abort and start together in IDLE: nothing happens.
        c0 = cyc;
        push(c0 + 1, exp_ia, exp_wa, 1'b0, 1'b0, 1'b0, 1'b0);
        push(c0 + 2, exp_ia, exp_wa, 1'b0, 1'b0, 1'b0, 1'b0);
        cfg_len = 16'd5;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        wait_until(c0 + 2);

        t0 = cyc;
        start_run(8'h20, 8'h04, 8'h30, 8'h08, 8, 2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        start_run(8'h01, 8'h01, 8'h02, 8'h01, 2, -1);
        wait_until(last_cyc);

        start_run(8'h50, 8'h01, 8'h60, 8'h01, 8, -1);
        tick();
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        exp_dones--;
        #1;
        check_zero("async_reset_midstream");
        exp_ia = '0;
        exp_wa = '0;
        #2;
        rst_n = 1'b1;
        tick();
        start_run(8'h05, 8'h02, 8'h06, 8'h03, 3, -1);
        wait_until(last_cyc);
        tick();

        n_chk++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drained: got %0d pending expected 0", exp_q.size());
        end
        n_chk++;
        if (done_seen != exp_dones) begin
            n_bad++;
            $display("FAIL done_count: got %0d expected %0d", done_seen, exp_dones);
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
